mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-requester round-robin arbiter that shares one 32-bit memory port between instruction fetch (requester 0) and load/store (requester 1) in the multi-cycle variant of the MIPS processor. It owns the select line of the shared 32-bit address/write-data multiplexer and sequences each transaction with a req/gnt/done handshake. It also enforces a ready timeout, so a stuck memory cannot lock the port.

## Interface
- N, 32, data/address width
- TIMEOUT, 15, max cycles a granted transaction waits for mem_ready before abort (1..255)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req0, req1  input  1  transaction request; held high until done/err of that requester
- addr0, addr1  input  N  requester address; stable while granted
- wdata0, wdata1  input  N  requester write data
- we0, we1  input  1  write enable for the request
- gnt0, gnt1  output  1  registered grant, one-hot or zero
- done0, done1  output  1  completion strobe (combinational: gnt_x & mem_ready)
- err0, err1  output  1  one-cycle timeout-abort pulse, registered
- mem_addr  output  N  muxed address: addr1 if gnt1 else addr0
- mem_wdata  output  N  muxed write data, same select
- mem_we  output  1  muxed we, gated by mem_valid
- mem_valid  output  1  gnt0 | gnt1
- mem_ready  input  1  memory completes the current access this cycle
- mem_rdata  input  N  read data, fanned out to both requesters, valid with done_x

## Operation
- States: IDLE, GRANT0, GRANT1. gnt0 = (state==GRANT0), gnt1 = (state==GRANT1). Mux select = gnt1.
- Register last_winner (1 bit) records the most recently granted requester.
- IDLE: only req0 -> GRANT0; only req1 -> GRANT1; both -> requester != last_winner; none -> stay.
- Entering GRANTx: set last_winner = x and clear wait counter to 0.
- GRANTx, mem_ready=1: transaction completes and done_x is high this cycle. Next state:
  - other requester's req high -> GRANT(other);
  - else own req_x high (back-to-back) -> GRANTx, counter cleared;
  - else IDLE.
- GRANTx, mem_ready=0: counter increments (saturating 8-bit).
  - When counter == TIMEOUT-1 and mem_ready still 0: next cycle err_x = 1 and state goes to IDLE. No done.
  - The aborted requester is last_winner, so it loses the next tie.
- Requester must drop req_x the cycle after done_x/err_x unless it issues a new transaction. A req_x drop while granted without done aborts silently to IDLE (no err, no done).
- mem_we = mem_valid & (gnt1 ? we1 : we0). Address/data mux is purely combinational: select=0 in IDLE, so mem_addr = addr0.

## Timing
- Reset (async): state IDLE, last_winner=1 (requester 0 wins first tie), counter 0, gnt0/gnt1/mem_valid/mem_we/done/err all 0. Outputs go low immediately on reset assertion, not at the next edge.
- Reset mid-transaction: grant dropped immediately; no done or err is generated for the killed transaction.
- Grant latency: req sampled at edge k in IDLE -> gnt high after edge k (1 cycle).
- Handoff on completion: zero idle cycles. done0 in cycle c -> gnt1 in cycle c+1.
- Minimum transaction: 1 granted cycle, with mem_ready high in the first grant cycle.
- Timeout: a grant starting cycle g with mem_ready stuck low gives err in cycle g+TIMEOUT and gnt low from that cycle.
- Simultaneous mem_ready and counter==TIMEOUT-1: completion wins; done is issued, no err.
- mem_ready while IDLE is ignored.

## Test plan
- Reset then req0=1 alone, addr0=0x0040_0000, mem_ready=1 on the first grant cycle -> gnt0 one cycle after req, mem_addr=0x0040_0000, done0 for 1 cycle, return to IDLE; gnt1 never high.
- req0 and req1 rise together from reset, addr1=0x1001_0000, we1=1, wdata1=0xDEAD_BEEF, mem_ready=1 each grant cycle -> gnt0 first, then gnt1 the very next cycle with mem_addr=0x1001_0000, mem_wdata=0xDEAD_BEEF, mem_we=1.
- Both requesters held high for 6 transactions, mem_ready=1 -> grants alternate 0,1,0,1,0,1 with no idle cycles.
- TIMEOUT=15, req1 alone, mem_ready=0 -> gnt1 high 15 cycles, err1 pulse in cycle 16 after grant, then IDLE. A following tie grants requester 0.
- mem_ready asserted exactly in the 15th grant cycle -> done1, no err1.
- Assert reset during GRANT0 with mem_ready=0 -> gnt0, mem_valid and mem_we drop before the next clock edge. After release, the state is IDLE and the first tie goes to requester 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the shared 32-bit memory port.
// Requester 0 is instruction fetch and requester 1 is load/store.
// It owns the address/write-data mux select and sequences each access with
// a req/gnt/done handshake. A ready timeout keeps a stuck memory from holding
// the port forever.
module mem_port_arbiter #(
  parameter int N       = 32,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [N-1:0] addr0,
  input  logic [N-1:0] addr1,
  input  logic [N-1:0] wdata0,
  input  logic [N-1:0] wdata1,
  input  logic         we0,
  input  logic         we1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic         err0,
  output logic         err1,
  output logic [N-1:0] rdata0,
  output logic [N-1:0] rdata1,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         mem_we,
  output logic         mem_valid,
  input  logic         mem_ready,
  input  logic [N-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  // Last wait-count value before a stalled access is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       lw_q, lw_d;       // most recently granted requester
  logic [7:0] cnt_q, cnt_d;     // cycles spent waiting for mem_ready
  logic       err0_q, err0_d;
  logic       err1_q, err1_d;

  // State, round-robin pointer, wait counter and error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lw_q    <= 1'b1;   // requester 0 wins the first tie
      cnt_q   <= 8'd0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lw_q    <= lw_d;
      cnt_q   <= cnt_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
    end
  end

  // Next-state logic. A completed access hands the port to the other
  // requester if it is waiting; otherwise the owner may go back to back.
  // A request dropped mid-access abandons it without done or err.
  always_comb begin
    state_d = state_q;
    lw_d    = lw_q;
    cnt_d   = 8'd0;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 && (!req1 || lw_q)) begin
          state_d = GRANT0;
          lw_d    = 1'b0;
        end else if (req1) begin
          state_d = GRANT1;
          lw_d    = 1'b1;
        end
      end
      GRANT0: begin
        if (mem_ready) begin
          if (req1) begin
            state_d = GRANT1;
            lw_d    = 1'b1;
          end else if (req0) begin
            state_d = GRANT0;
          end else begin
            state_d = IDLE;
          end
        end else if (!req0) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          err0_d  = 1'b1;
        end else begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      GRANT1: begin
        if (mem_ready) begin
          if (req0) begin
            state_d = GRANT0;
            lw_d    = 1'b0;
          end else if (req1) begin
            state_d = GRANT1;
          end else begin
            state_d = IDLE;
          end
        end else if (!req1) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          err1_d  = 1'b1;
        end else begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grants come straight from the state register, so reset clears them at once.
  assign gnt0      = (state_q == GRANT0);
  assign gnt1      = (state_q == GRANT1);
  assign mem_valid = gnt0 | gnt1;
  assign done0     = gnt0 & mem_ready;
  assign done1     = gnt1 & mem_ready;
  assign err0      = err0_q;
  assign err1      = err1_q;

  // Shared mux: select is gnt1, so IDLE presents requester 0's address.
  assign mem_addr  = gnt1 ? addr1 : addr0;
  assign mem_wdata = gnt1 ? wdata1 : wdata0;
  assign mem_we    = mem_valid & (gnt1 ? we1 : we0);

  // Read data fans out to both requesters; each qualifies it with its done.
  assign rdata0 = mem_rdata;
  assign rdata1 = mem_rdata;

endmodule
